// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared encodings for the multi-cycle MIPS-subset controller:
//   - state_e   : controller state, also exported on state_o for debug
//   - OP_*      : supported opcodes from IR[31:26]
//   - ALUOP_*   : ALUOp_o encodings consumed by ALU_Control
//   - PCSRC_*   : PCSource_o mux encodings
//   - SRCB_*    : ALUSrcB_o mux encodings
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        WB_MEM   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        ERROR    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // States that hold a memory request open until ack (or timeout).
    function automatic logic is_mem_state(input state_e s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts wait cycles of a req/ack memory handshake and flags a timeout.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-low reset
//   req_i     : a request is outstanding this cycle
//   ack_i     : memory completes the access this cycle
//   expire_o  : this req cycle without ack is the LIMIT-th consecutive one
module mem_wait_timer #(
    parameter int LIMIT = 16,
    parameter int CNT_W = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic ack_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stall;

    assign stall = req_i && !ack_i;

    // The counter holds the number of stalled cycles already seen, so the
    // LIMIT-th stall is detected while the count still reads LIMIT-1. An ack
    // in that same cycle suppresses stall, which lets the ack win the race.
    assign expire_o = stall && (cnt_q == CNT_W'(LIMIT - 1));

    // Dropping req (leaving the waiting state) or an ack restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || ack_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_control.sv
// mc_control
// Multi-cycle main controller for the MIPS-subset CPU. Sequences each
// instruction through fetch/decode/execute/memory/writeback over a shared ALU
// and a single unified memory port with a req/ack handshake and timeout.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-low reset
//   Op_i                : opcode from IR[31:26]
//   mem_ack_i           : memory completes current access
//   mem_req_o, MemRead_o, MemWrite_o, IorD_o : memory port controls
//   IRWrite_o, PCWrite_o, PCWriteCond_o, PCSource_o : IR / PC controls
//   ALUOp_o, ALUSrcA_o, ALUSrcB_o : ALU controls
//   RegDst_o, MemtoReg_o, RegWrite_o : register file controls
//   illegal_o           : one-cycle pulse on unsupported opcode
//   err_o               : sticky memory-timeout error
//   state_o             : current state, debug
module mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] Op_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IorD_o,
    output logic       IRWrite_o,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic [1:0] PCSource_o,
    output logic [1:0] ALUOp_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       RegWrite_o,
    output logic       illegal_o,
    output logic       err_o,
    output logic [3:0] state_o
);

    state_e state_q;
    state_e state_d;
    logic   waiting;
    logic   expire;

    // Derived from state only (not from mem_req_o) to keep the timer free of
    // a combinational loop back through the decode block.
    assign waiting = rst_i && is_mem_state(state_q);

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (waiting),
        .ack_i    (mem_ack_i),
        .expire_o (expire)
    );

    // State register; reset wins even in the middle of a memory access.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. Everything is Moore from state_q except
    // the FETCH ack strobes and the DECODE illegal pulse. While rst_i is low
    // the whole decode is skipped so every output reads 0.
    always_comb begin
        state_d       = state_q;
        mem_req_o     = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IorD_o        = 1'b0;
        IRWrite_o     = 1'b0;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        PCSource_o    = PCSRC_ALU;
        ALUOp_o       = ALUOP_ADD;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = SRCB_RT;
        RegDst_o      = 1'b0;
        MemtoReg_o    = 1'b0;
        RegWrite_o    = 1'b0;
        illegal_o     = 1'b0;
        err_o         = 1'b0;
        state_o       = 4'd0;
        if (rst_i) begin
            state_o = state_q;
            case (state_q)
                FETCH: begin
                    mem_req_o = 1'b1;
                    MemRead_o = 1'b1;
                    ALUSrcB_o = SRCB_FOUR;
                    if (mem_ack_i) begin
                        IRWrite_o = 1'b1;
                        PCWrite_o = 1'b1;
                        state_d   = DECODE;
                    end else if (expire) begin
                        state_d = ERROR;
                    end
                end
                DECODE: begin
                    ALUSrcB_o = SRCB_IMM_SH2;
                    case (Op_i)
                        OP_RTYPE: state_d = EXEC_R;
                        OP_ADDI:  state_d = EXEC_I;
                        OP_LW,
                        OP_SW:    state_d = MEM_ADDR;
                        OP_BEQ:   state_d = BRANCH;
                        OP_J:     state_d = JUMP;
                        default: begin
                            illegal_o = 1'b1;
                            state_d   = FETCH;
                        end
                    endcase
                end
                EXEC_R: begin
                    ALUSrcA_o = 1'b1;
                    ALUSrcB_o = SRCB_RT;
                    ALUOp_o   = ALUOP_FUNCT;
                    state_d   = WB_R;
                end
                WB_R: begin
                    RegDst_o   = 1'b1;
                    RegWrite_o = 1'b1;
                    state_d    = FETCH;
                end
                EXEC_I: begin
                    ALUSrcA_o = 1'b1;
                    ALUSrcB_o = SRCB_IMM;
                    state_d   = WB_I;
                end
                WB_I: begin
                    RegWrite_o = 1'b1;
                    state_d    = FETCH;
                end
                MEM_ADDR: begin
                    ALUSrcA_o = 1'b1;
                    ALUSrcB_o = SRCB_IMM;
                    state_d   = (Op_i == OP_LW) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    mem_req_o = 1'b1;
                    MemRead_o = 1'b1;
                    IorD_o    = 1'b1;
                    if (mem_ack_i) begin
                        state_d = WB_MEM;
                    end else if (expire) begin
                        state_d = ERROR;
                    end
                end
                WB_MEM: begin
                    MemtoReg_o = 1'b1;
                    RegWrite_o = 1'b1;
                    state_d    = FETCH;
                end
                MEM_WR: begin
                    mem_req_o  = 1'b1;
                    MemWrite_o = 1'b1;
                    IorD_o     = 1'b1;
                    if (mem_ack_i) begin
                        state_d = FETCH;
                    end else if (expire) begin
                        state_d = ERROR;
                    end
                end
                BRANCH: begin
                    ALUSrcA_o     = 1'b1;
                    ALUSrcB_o     = SRCB_RT;
                    ALUOp_o       = ALUOP_SUB;
                    PCWriteCond_o = 1'b1;
                    PCSource_o    = PCSRC_ALUOUT;
                    state_d       = FETCH;
                end
                JUMP: begin
                    PCWrite_o  = 1'b1;
                    PCSource_o = PCSRC_JUMP;
                    state_d    = FETCH;
                end
                ERROR: begin
                    err_o = 1'b1;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control
// Drives instruction sequences with random opcodes and memory wait states
// into mc_control and compares every cycle's outputs with a reference model
// that expands each instruction into its expected per-cycle control vectors.
module tb_mc_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2;
    localparam logic [3:0] S_WB_R  = 4'd3,  S_EXEC_I = 4'd4,  S_WB_I   = 4'd5;
    localparam logic [3:0] S_MADDR = 4'd6,  S_MEM_RD = 4'd7,  S_WB_MEM = 4'd8;
    localparam logic [3:0] S_MEM_WR = 4'd9, S_BRANCH = 4'd10, S_JUMP   = 4'd11;
    localparam logic [3:0] S_ERROR = 4'd12;

    typedef struct packed {
        logic       req, rd, wr, iord, irw, pcw, pcwc;
        logic [1:0] pcsrc, aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       regdst, m2r, regw, ill, err;
        logic [3:0] st;
    } outs_t;

    typedef struct {
        bit         rstn;
        bit         ack;
        logic [5:0] op;
        outs_t      exp;
    } cyc_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [5:0] Op_i = 6'd0;
    logic       mem_ack_i = 1'b0;
    logic       mem_req_o, MemRead_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o;
    logic       PCWriteCond_o, ALUSrcA_o, RegDst_o, MemtoReg_o, RegWrite_o;
    logic       illegal_o, err_o;
    logic [1:0] PCSource_o, ALUOp_o, ALUSrcB_o;
    logic [3:0] state_o;

    int   vecCount = 0;
    int   missCount = 0;
    cyc_t plan[$];

    always #5 clk_i = ~clk_i;

    mc_control #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .Op_i          (Op_i),
        .mem_ack_i     (mem_ack_i),
        .mem_req_o     (mem_req_o),
        .MemRead_o     (MemRead_o),
        .MemWrite_o    (MemWrite_o),
        .IorD_o        (IorD_o),
        .IRWrite_o     (IRWrite_o),
        .PCWrite_o     (PCWrite_o),
        .PCWriteCond_o (PCWriteCond_o),
        .PCSource_o    (PCSource_o),
        .ALUOp_o       (ALUOp_o),
        .ALUSrcA_o     (ALUSrcA_o),
        .ALUSrcB_o     (ALUSrcB_o),
        .RegDst_o      (RegDst_o),
        .MemtoReg_o    (MemtoReg_o),
        .RegWrite_o    (RegWrite_o),
        .illegal_o     (illegal_o),
        .err_o         (err_o),
        .state_o       (state_o)
    );

    // Expected controls for one step of an instruction, read off the
    // controller's published step table.
    function automatic outs_t stepOut(input logic [3:0] st, input bit ack, input logic [5:0] op);
        outs_t o;
        o = '0;
        o.st = st;
        case (st)
            S_FETCH:  begin o.req = 1; o.rd = 1; o.srcb = 2'b01; o.irw = ack; o.pcw = ack; end
            S_DECODE: begin o.srcb = 2'b11; o.ill = !isLegal(op); end
            S_EXEC_R: begin o.srca = 1; o.srcb = 2'b00; o.aluop = 2'b11; end
            S_WB_R:   begin o.regdst = 1; o.regw = 1; end
            S_EXEC_I: begin o.srca = 1; o.srcb = 2'b10; end
            S_WB_I:   begin o.regw = 1; end
            S_MADDR:  begin o.srca = 1; o.srcb = 2'b10; end
            S_MEM_RD: begin o.req = 1; o.rd = 1; o.iord = 1; end
            S_WB_MEM: begin o.m2r = 1; o.regw = 1; end
            S_MEM_WR: begin o.req = 1; o.wr = 1; o.iord = 1; end
            S_BRANCH: begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 2'b01; end
            S_JUMP:   begin o.pcw = 1; o.pcsrc = 2'b10; end
            S_ERROR:  begin o.err = 1; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    function automatic bit isLegal(input logic [5:0] op);
        return op == OP_R || op == OP_ADDI || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_J;
    endfunction

    // Appends one clock cycle of stimulus plus its expected outputs.
    function automatic void pushCyc(input bit rstn, input bit ack, input logic [5:0] op, input outs_t exp);
        cyc_t c;
        c.rstn = rstn;
        c.ack  = ack;
        c.op   = op;
        c.exp  = exp;
        plan.push_back(c);
    endfunction

    // A handshake step: 'waits' stalled cycles followed by the ack cycle.
    function automatic void memStep(input logic [3:0] st, input int waits, input logic [5:0] op);
        for (int i = 0; i < waits; i++) pushCyc(1, 0, op, stepOut(st, 0, op));
        pushCyc(1, 1, op, stepOut(st, 1, op));
    endfunction

    // A non-handshake step; ack is random there and must be ignored.
    function automatic void plainStep(input logic [3:0] st, input logic [5:0] op);
        pushCyc(1, 1'($urandom_range(0, 1)), op, stepOut(st, 0, op));
    endfunction

    // Expands a whole instruction into its expected cycle sequence.
    function automatic void planInstr(input logic [5:0] op, input int wFetch, input int wMem);
        memStep(S_FETCH, wFetch, op);
        plainStep(S_DECODE, op);
        case (op)
            OP_R:    begin plainStep(S_EXEC_R, op); plainStep(S_WB_R, op); end
            OP_ADDI: begin plainStep(S_EXEC_I, op); plainStep(S_WB_I, op); end
            OP_LW:   begin plainStep(S_MADDR, op); memStep(S_MEM_RD, wMem, op); plainStep(S_WB_MEM, op); end
            OP_SW:   begin plainStep(S_MADDR, op); memStep(S_MEM_WR, wMem, op); end
            OP_BEQ:  plainStep(S_BRANCH, op);
            OP_J:    plainStep(S_JUMP, op);
            default: ;
        endcase
    endfunction

    function automatic outs_t sampleDut();
        outs_t o;
        o.req = mem_req_o;   o.rd = MemRead_o;      o.wr = MemWrite_o;
        o.iord = IorD_o;     o.irw = IRWrite_o;     o.pcw = PCWrite_o;
        o.pcwc = PCWriteCond_o; o.pcsrc = PCSource_o; o.aluop = ALUOp_o;
        o.srca = ALUSrcA_o;  o.srcb = ALUSrcB_o;    o.regdst = RegDst_o;
        o.m2r = MemtoReg_o;  o.regw = RegWrite_o;   o.ill = illegal_o;
        o.err = err_o;       o.st = state_o;
        return o;
    endfunction

    task automatic checkOutput(input string tag, input outs_t got, input outs_t exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got=%h expected=%h (state got %0d expected %0d)",
                     tag, got, exp, got.st, exp.st);
        end
    endtask

    // Drives one planned cycle mid-period and checks once outputs settle.
    task automatic applyStimulus(input cyc_t c, input int idx);
        @(negedge clk_i);
        rst_i     = c.rstn;
        mem_ack_i = c.ack;
        Op_i      = c.op;
        #1;
        checkOutput($sformatf("cyc%0d_st%0d_rst%0d", idx, c.exp.st, c.rstn), sampleDut(), c.exp);
    endtask

    task automatic runPlan();
        int idx;
        idx = 0;
        while (plan.size() > 0) begin
            applyStimulus(plan.pop_front(), idx);
            idx++;
        end
    endtask

    function automatic logic [5:0] randOp();
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0: op = OP_R;
            1: op = OP_ADDI;
            2: op = OP_LW;
            3: op = OP_SW;
            4: op = OP_BEQ;
            5: op = OP_J;
            default: begin
                op = 6'($urandom_range(0, 63));
                while (isLegal(op)) op = 6'($urandom_range(0, 63));
            end
        endcase
        return op;
    endfunction

    function automatic int randWait();
        return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    endfunction

    initial begin
        // Power-up reset with ack high: all outputs must stay 0.
        pushCyc(0, 1, OP_R, '0);
        pushCyc(0, 1, OP_R, '0);
        // Directed instruction mix.
        planInstr(OP_R, 0, 0);
        planInstr(OP_LW, 0, 3);
        planInstr(OP_SW, 0, 0);
        planInstr(OP_BEQ, 0, 0);
        planInstr(OP_BAD, 0, 0);
        planInstr(OP_J, 0, 0);
        planInstr(OP_ADDI, 0, 0);
        // Ack on the 16th request cycle beats the timeout.
        planInstr(OP_R, 15, 0);
        planInstr(OP_SW, 2, 15);
        runPlan();

        // Timeout in FETCH: 16 stalled cycles then ERROR until reset.
        for (int i = 0; i < 16; i++) pushCyc(1, 0, OP_R, stepOut(S_FETCH, 0, OP_R));
        for (int i = 0; i < 4; i++) pushCyc(1, 1'($urandom_range(0, 1)), OP_R, stepOut(S_ERROR, 0, OP_R));
        pushCyc(0, 1, OP_R, '0);
        planInstr(OP_ADDI, 1, 0);
        // Timeout in MEM_RD.
        memStep(S_FETCH, 0, OP_LW);
        plainStep(S_DECODE, OP_LW);
        plainStep(S_MADDR, OP_LW);
        for (int i = 0; i < 16; i++) pushCyc(1, 0, OP_LW, stepOut(S_MEM_RD, 0, OP_LW));
        pushCyc(1, 0, OP_LW, stepOut(S_ERROR, 0, OP_LW));
        pushCyc(0, 0, OP_LW, '0);
        // Reset in the middle of a MEM_RD wait must also clear the counter,
        // so a following fetch can still stall 15 cycles without error.
        memStep(S_FETCH, 0, OP_LW);
        plainStep(S_DECODE, OP_LW);
        plainStep(S_MADDR, OP_LW);
        pushCyc(1, 0, OP_LW, stepOut(S_MEM_RD, 0, OP_LW));
        pushCyc(1, 0, OP_LW, stepOut(S_MEM_RD, 0, OP_LW));
        pushCyc(0, 0, OP_LW, '0);
        planInstr(OP_R, 15, 0);
        runPlan();

        // Random instruction stream.
        for (int n = 0; n < 80; n++) begin
            planInstr(randOp(), randWait(), randWait());
        end
        runPlan();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle main controller for the MIPS-subset CPU. It replaces single-cycle opcode decode with a state machine.
- Each instruction is sequenced through fetch, decode, execute, memory and writeback steps over a shared ALU and a single unified memory port.
- Drives the datapath mux/enable signals and runs a req/ack handshake with memory, including a timeout.
- Sits between the IR opcode field and the datapath; ALUOp_o feeds the existing ALU_Control.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles mem_req_o may stay high without mem_ack_i before ERROR.
- CNT_W, 5: wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- Op_i  in  6  opcode from IR[31:26].
- mem_ack_i  in  1  memory completes the current access this cycle.
- mem_req_o  out  1  memory access request.
- MemRead_o  out  1  read access.
- MemWrite_o  out  1  write access.
- IorD_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite_o  out  1  load IR.
- PCWrite_o  out  1  unconditional PC load.
- PCWriteCond_o  out  1  PC load if ALU zero.
- PCSource_o  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp_o  out  2  ALU operation: 00 = add, 01 = sub, 11 = funct.
- ALUSrcA_o  out  1  ALU A: 0 = PC, 1 = rs.
- ALUSrcB_o  out  2  ALU B: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- RegDst_o  out  1  destination register: 1 = rd, 0 = rt.
- MemtoReg_o  out  1  writeback data: 1 = MDR, 0 = ALUOut.
- RegWrite_o  out  1  register file write.
- illegal_o  out  1  one-cycle pulse on an unsupported opcode.
- err_o  out  1  sticky memory-timeout error.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset: rst_i low at a clock edge forces state FETCH, wait counter 0, err_o 0. This applies even mid-access; mem_req_o drops the next cycle. Outputs are Moore-decoded from state; while rst_i is low every output is 0.
- Outputs default to 0 in every state unless listed below.
- Opcodes: R-type 000000, addi 001000, lw 100011, sw 101011, beq 000100, j 000010.
- FETCH:
  - Outputs: mem_req_o=1, MemRead_o=1, IorD_o=0, ALUSrcA_o=0, ALUSrcB_o=01, ALUOp_o=00, PCSource_o=00.
  - On mem_ack_i: IRWrite_o=1 and PCWrite_o=1, both combinational on ack in this cycle only; go to DECODE.
- DECODE:
  - Outputs: ALUSrcA_o=0, ALUSrcB_o=11, ALUOp_o=00 (branch target into ALUOut).
  - Next state by Op_i: R-type -> EXEC_R; addi -> EXEC_I; lw/sw -> MEM_ADDR; beq -> BRANCH; j -> JUMP.
  - Any other opcode: illegal_o=1 this cycle -> FETCH.
- EXEC_R: ALUSrcA_o=1, ALUSrcB_o=00, ALUOp_o=11 -> WB_R.
- WB_R: RegDst_o=1, MemtoReg_o=0, RegWrite_o=1 -> FETCH.
- EXEC_I: ALUSrcA_o=1, ALUSrcB_o=10, ALUOp_o=00 -> WB_I.
- WB_I: RegDst_o=0, MemtoReg_o=0, RegWrite_o=1 -> FETCH.
- MEM_ADDR: ALUSrcA_o=1, ALUSrcB_o=10, ALUOp_o=00. Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_req_o=1, MemRead_o=1, IorD_o=1. Leaves on mem_ack_i -> WB_MEM.
- WB_MEM: RegDst_o=0, MemtoReg_o=1, RegWrite_o=1 -> FETCH.
- MEM_WR: mem_req_o=1, MemWrite_o=1, IorD_o=1. Leaves on mem_ack_i -> FETCH.
- BRANCH: ALUSrcA_o=1, ALUSrcB_o=00, ALUOp_o=01, PCWriteCond_o=1, PCSource_o=01 -> FETCH.
- JUMP: PCWrite_o=1, PCSource_o=10 -> FETCH.
- Op_i is sampled only in DECODE and MEM_ADDR; the IR holds it stable through the instruction.
- Memory handshake and timeout (FETCH, MEM_RD, MEM_WR):
  - A req cycle without ack increments the counter; the counter clears on ack or on leaving the state.
  - Ack in the first req cycle means zero wait states.
  - If the counter reaches MEM_TIMEOUT without ack: go to ERROR.
  - If ack arrives in the same cycle the counter would hit the limit, ack wins.
- ERROR: all controls 0, err_o=1. Exit only by reset.
- Minimum CPI with zero-wait memory: R/addi 4, lw 5, sw 4, beq 3, j 3.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state encoding (4-bit localparams: FETCH=0 … ERROR=12);
  - opcode constants;
  - ALUOp, PCSource and ALUSrcB encodings.
- One natural sub-module: mem_wait_timer (counter, clear, timeout flag), also reusable by a future cache controller.
- Next-state and output decode stay in mc_control.

Test Plan:
- Reset, then R-type with ack held high:
  - IRWrite_o/PCWrite_o in cycle 1;
  - ALUOp_o=11 in cycle 3;
  - RegWrite_o=1, RegDst_o=1 in cycle 4;
  - back in FETCH in cycle 5.
- lw with ack delayed 3 cycles in MEM_RD:
  - mem_req_o/IorD_o high for exactly 4 cycles;
  - then WB_MEM with MemtoReg_o=1, RegWrite_o=1.
- sw then beq, zero-wait: sw shows MemWrite_o=1 for 1 cycle and no RegWrite_o; beq shows PCWriteCond_o=1, ALUOp_o=01, PCSource_o=01 in cycle 3.
- Op_i=111111 in DECODE: illegal_o pulses 1 cycle, state returns to FETCH, no RegWrite_o/MemWrite_o.
- Timeout:
  - no ack for 16 cycles in FETCH -> state ERROR, err_o=1, all controls 0 until rst_i low;
  - ack on the 16th cycle -> DECODE with no error.
- rst_i low mid-MEM_RD wait: next state FETCH, err_o=0, counter 0, mem_req_o low for the reset cycle.
